mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single memory port with fetch starvation guard
module mem_arbiter #(
    parameter int STARVE_MAX = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        dm_read_i,
    input  logic        dm_write_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        stall_o
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;

    logic dm_req;
    logic starving;
    logic grant_dm;
    logic grant_if;
    logic if_ack;
    logic dm_ack;

    // Data port normally wins; a fetch that has waited through CNT_MAX data grants wins instead.
    assign dm_req   = dm_read_i | dm_write_i;
    assign starving = if_req_i && (starve_cnt_q == CNT_MAX);
    assign grant_dm = (state_q == IDLE) && dm_req && !starving;
    assign grant_if = (state_q == IDLE) && if_req_i && !grant_dm;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: grants only from IDLE, return to IDLE on memory completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d = BUSY_DM;
                end else if (grant_if) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            BUSY_DM: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: memory request while busy, ack combinationally on completion
    always_comb begin
        mem_req_o = 1'b0;
        if_ack    = 1'b0;
        dm_ack    = 1'b0;
        case (state_q)
            BUSY_IF: begin
                mem_req_o = 1'b1;
                if_ack    = mem_ready_i;
            end
            BUSY_DM: begin
                mem_req_o = 1'b1;
                dm_ack    = mem_ready_i;
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

    // Datapath next-state: latch the winner's command at grant, capture read data at ack
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if (grant_dm) begin
            mem_addr_d  = dm_addr_i;
            mem_we_d    = dm_write_i;
            mem_wdata_d = dm_wdata_i;
            if (if_req_i && (starve_cnt_q != CNT_MAX)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end else if (grant_if) begin
            mem_addr_d   = if_addr_i;
            mem_we_d     = 1'b0;
            mem_wdata_d  = 32'd0;
            starve_cnt_d = '0;
        end
        if (if_ack) begin
            if_rdata_d = mem_rdata_i;
        end
        if (dm_ack) begin
            dm_rdata_d = mem_rdata_i;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            if_rdata_q   <= 32'd0;
            dm_rdata_q   <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign if_ack_o    = if_ack;
    assign dm_ack_o    = dm_ack;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    // Read data passes straight through in the ack cycle, otherwise shows the last acked word.
    assign if_rdata_o  = if_ack ? mem_rdata_i : if_rdata_q;
    assign dm_rdata_o  = dm_ack ? mem_rdata_i : dm_rdata_q;
    assign stall_o     = (if_req_i & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_read_i;
    logic        dm_write_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    logic        stall_o;

    mem_arbiter #(.STARVE_MAX(2)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .dm_read_i   (dm_read_i),
        .dm_write_i  (dm_write_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ack_o    (dm_ack_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .stall_o     (stall_o)
    );

    typedef struct {
        bit          is_dm;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat = 2;
    bit   force_mode = 0;
    bit   force_ready = 0;
    bit   chk_zero = 0;
    bit   chk_end = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic void push(bit is_dm, logic [31:0] addr, bit we, logic [31:0] wdata, logic [31:0] rdata);
        exp_t e;
        e.is_dm = is_dm; e.addr = addr; e.we = we; e.wdata = wdata; e.rdata = rdata;
        exp_q.push_back(e);
    endfunction

    // Memory model: ready lat cycles after the first mem_req_o cycle; data = ~addr, except 0x10.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready_i = 0;
        mem_rdata_i = 0;
        forever begin
            @(posedge clk); #1;
            if (force_mode) begin
                cnt = 0;
                mem_ready_i = force_ready;
                mem_rdata_i = 32'h1234_5678;
            end else if (mem_req_o) begin
                cnt++;
                mem_ready_i = (cnt == lat + 1);
                mem_rdata_i = (mem_addr_o == 32'h10) ? 32'h00A0_0093 : ~mem_addr_o;
            end else begin
                cnt = 0;
                mem_ready_i = 0;
                mem_rdata_i = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks cycle invariants.
    initial begin
        bit          busy_prev;
        logic [31:0] held_addr;
        exp_t        e;
        busy_prev = 0;
        held_addr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n_i) begin
                busy_prev = 0;
            end else begin
                chk("stall", 32'(stall_o),
                    32'((if_req_i & ~if_ack_o) | ((dm_read_i | dm_write_i) & ~dm_ack_o)));
                if (mem_req_o) begin
                    if (busy_prev) chk("addr_stable", mem_addr_o, held_addr);
                    held_addr = mem_addr_o;
                end
                busy_prev = mem_req_o;
                if (if_ack_o && dm_ack_o) chk("ack_exclusive", 32'd1, 32'd0);
                if (if_ack_o || dm_ack_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_kind", 32'(dm_ack_o), 32'(e.is_dm));
                        chk("mem_addr", mem_addr_o, e.addr);
                        chk("mem_we", 32'(mem_we_o), 32'(e.we));
                        if (e.we) chk("mem_wdata", mem_wdata_o, e.wdata);
                        chk("rdata", dm_ack_o ? dm_rdata_o : if_rdata_o, e.rdata);
                    end
                end
                if (chk_zero) begin
                    chk("zero_mem_req", 32'(mem_req_o), 32'd0);
                    chk("zero_mem_we", 32'(mem_we_o), 32'd0);
                    chk("zero_mem_addr", mem_addr_o, 32'd0);
                    chk("zero_mem_wdata", mem_wdata_o, 32'd0);
                    chk("zero_acks", 32'({if_ack_o, dm_ack_o}), 32'd0);
                    chk("zero_if_rdata", if_rdata_o, 32'd0);
                    chk("zero_dm_rdata", dm_rdata_o, 32'd0);
                end
                if (chk_end) chk("queue_empty", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    task automatic wait_ack(input bit dm);
        int n;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (dm ? dm_ack_o : if_ack_o) break;
        end
        if (n == 64) begin
            $display("FAIL ack_timeout: port %s no ack within 64 cycles", dm ? "dm" : "if");
            $fatal(1, "timeout");
        end
    endtask

    task automatic if_op(input logic [31:0] a);
        if_addr_i = a;
        if_req_i = 1;
        wait_ack(0);
        @(posedge clk); #1;
        if_req_i = 0;
    endtask

    task automatic dm_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        dm_read_i = rd; dm_write_i = wr; dm_addr_i = a; dm_wdata_i = wd;
        wait_ack(1);
        @(posedge clk); #1;
        dm_read_i = 0; dm_write_i = 0;
    endtask

    // Load request held high across three back-to-back loads at a, a+4, a+8.
    task automatic dm_seq3(input logic [31:0] a);
        dm_read_i = 1;
        for (int i = 0; i < 3; i++) begin
            dm_addr_i = a + 32'(i * 4);
            wait_ack(1);
            @(posedge clk); #1;
        end
        dm_read_i = 0;
    endtask

    initial begin
        int n;
        rst_n_i = 0;
        if_req_i = 0; if_addr_i = 0;
        dm_read_i = 0; dm_write_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_i = 1;
        chk_zero = 1;
        @(posedge clk); #1;
        chk_zero = 0;

        // Single fetch, ready two cycles after mem_req_o
        lat = 2;
        push(0, 32'h10, 0, 32'h0, 32'h00A0_0093);
        if_op(32'h10);

        // Simultaneous fetch and store: store first, then fetch
        lat = 1;
        push(1, 32'h100, 1, 32'hDEAD_BEEF, 32'hFFFF_FEFF);
        push(0, 32'h20, 0, 32'h0, 32'hFFFF_FFDF);
        fork
            if_op(32'h20);
            dm_op(0, 1, 32'h100, 32'hDEAD_BEEF);
        join

        // Starvation: DM, DM, IF, DM
        push(1, 32'h200, 0, 32'h0, 32'hFFFF_FDFF);
        push(1, 32'h204, 0, 32'h0, 32'hFFFF_FDFB);
        push(0, 32'h40, 0, 32'h0, 32'hFFFF_FFBF);
        push(1, 32'h208, 0, 32'h0, 32'hFFFF_FDF7);
        fork
            if_op(32'h40);
            dm_seq3(32'h200);
        join

        // Same pattern again: order repeats only if the counter went back to 0
        push(1, 32'h400, 0, 32'h0, 32'hFFFF_FBFF);
        push(1, 32'h404, 0, 32'h0, 32'hFFFF_FBFB);
        push(0, 32'h80, 0, 32'h0, 32'hFFFF_FF7F);
        push(1, 32'h408, 0, 32'h0, 32'hFFFF_FBF7);
        fork
            if_op(32'h80);
            dm_seq3(32'h400);
        join

        // Long stall: five not-ready cycles
        lat = 5;
        push(1, 32'h300, 0, 32'h0, 32'hFFFF_FCFF);
        dm_op(1, 0, 32'h300, 32'h0);

        // Read and write both high: one write transaction
        lat = 1;
        push(1, 32'h304, 1, 32'h0BAD_F00D, 32'hFFFF_FCFB);
        dm_op(1, 1, 32'h304, 32'h0BAD_F00D);

        // Reset during BUSY_DM, then ready asserted while idle
        force_mode = 1;
        force_ready = 0;
        dm_read_i = 1; dm_addr_i = 32'h308;
        for (n = 0; n < 16; n++) begin
            @(negedge clk);
            if (mem_req_o) break;
        end
        if (n == 16) begin
            $display("FAIL grant_timeout: no mem_req_o for dm 0x308");
            $fatal(1, "timeout");
        end
        @(posedge clk); #1;
        rst_n_i = 0;
        dm_read_i = 0;
        @(posedge clk); #1;
        rst_n_i = 1;
        force_ready = 1;
        chk_zero = 1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk_zero = 0;
        force_ready = 0;
        force_mode = 0;

        // Arbiter still works after the abandoned transaction
        lat = 0;
        push(0, 32'h10, 0, 32'h0, 32'h00A0_0093);
        if_op(32'h10);

        chk_end = 1;
        @(posedge clk); #1;
        chk_end = 0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
